// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and a shared byte-write RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8
);
  localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [NUM_COL-1:0]    req0_we;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_lock;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [NUM_COL-1:0]    req1_we;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_lock;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  ram_en;
  logic [NUM_COL-1:0]    ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  lock_abort;

  modport slave (
    input  req0_valid, req0_addr, req0_we, req0_wdata, req0_lock,
    input  req1_valid, req1_addr, req1_we, req1_wdata, req1_lock,
    input  ram_dout,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_en, ram_we, ram_addr, ram_din, lock_abort
  );

  modport master (
    output req0_valid, req0_addr, req0_we, req0_wdata, req0_lock,
    output req1_valid, req1_addr, req1_we, req1_wdata, req1_lock,
    output ram_dout,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_en, ram_we, ram_addr, ram_din, lock_abort
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for one shared RAM port: round-robin grants, locked bursts
// bounded by LOCK_MAX beats, and single-cycle response routing from a registered owner tag.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned LOCK_MAX   = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int unsigned CNT_W      = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;   // requester favoured on the next both-valid ARB cycle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] beat_cnt;
  logic             abort_q, abort_d;
  logic             rsp_pend_q;
  logic             owner_q;

  logic             gnt;
  logic             rdy0, rdy1;
  logic             acc;
  logic             lock_sel;

  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [NUM_COL-1:0]    we_sel;
  logic [DATA_WIDTH-1:0] din_sel;

  // Grant selection, accept detection and lock/counter next-state
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    gnt      = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;

    case (state_q)
      ARB: begin
        gnt  = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
        rdy0 = bus.req0_valid & ~gnt;
        rdy1 = bus.req1_valid & gnt;
      end
      LOCK0: rdy0 = 1'b1;
      LOCK1: begin
        gnt  = 1'b1;
        rdy1 = 1'b1;
      end
      default: ;
    endcase

    if (rst) begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end

    acc      = (bus.req0_valid & rdy0) | (bus.req1_valid & rdy1);
    lock_sel = gnt ? bus.req1_lock : bus.req0_lock;
    beat_cnt = (state_q == ARB) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    if (acc) begin
      prio_d = ~gnt;
      if (!lock_sel) begin
        state_d = ARB;
        cnt_d   = '0;
      end else if (beat_cnt >= CNT_W'(LOCK_MAX)) begin
        // Burst hit its limit: the beat completes but ownership is revoked
        state_d = ARB;
        cnt_d   = '0;
        abort_d = 1'b1;
      end else begin
        state_d = gnt ? LOCK1 : LOCK0;
        cnt_d   = beat_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      rsp_pend_q <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      rsp_pend_q <= acc;
      owner_q    <= gnt;
    end
  end

  assign addr_sel = gnt ? bus.req1_addr  : bus.req0_addr;
  assign we_sel   = gnt ? bus.req1_we    : bus.req0_we;
  assign din_sel  = gnt ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.ram_en     = acc;
  assign bus.ram_we     = acc ? we_sel : '0;
  assign bus.ram_addr   = addr_sel;
  assign bus.ram_din    = din_sel;

  // RAM read data is registered, so it lines up with the tagged response cycle
  assign bus.rsp0_valid = rsp_pend_q & ~owner_q & ~rst;
  assign bus.rsp1_valid = rsp_pend_q &  owner_q & ~rst;
  assign bus.rsp0_rdata = bus.ram_dout;
  assign bus.rsp1_rdata = bus.ram_dout;
  assign bus.lock_abort = abort_q & ~rst;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a transaction-level
// ownership model and a golden memory image.
module tb_dmem_port_arbiter;
  localparam int unsigned AW       = 11;
  localparam int unsigned NC       = 4;
  localparam int unsigned CW       = 8;
  localparam int unsigned DW       = NC * CW;
  localparam int unsigned LOCK_MAX = 8;
  localparam int unsigned DEPTH    = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(CW)) bus ();

  dmem_port_arbiter #(
    .ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(CW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM behind the port: registered read-first output, byte-column writes
  logic [DW-1:0] ram  [0:DEPTH-1];
  logic [DW-1:0] gold [0:DEPTH-1];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_dout <= ram[bus.ram_addr];
      for (int b = 0; b < int'(NC); b++)
        if (bus.ram_we[b]) ram[bus.ram_addr][b*CW +: CW] <= bus.ram_din[b*CW +: CW];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the port, who is favoured, beats in the current burst
  int            m_owner = -1;
  int            m_pref  = 0;
  int            m_beats = 0;
  bit            m_rv    = 1'b0;
  int            m_rwho  = 0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_abort = 1'b0;

  initial begin : compare
    int            g;
    int            acc;
    bit [1:0]      v;
    bit [1:0]      rdy;
    logic [AW-1:0] a;
    logic [NC-1:0] we;
    logic [DW-1:0] wd;
    bit            lk;
    forever begin
      @(negedge clk);
      #1;
      v   = {bus.req1_valid, bus.req0_valid};
      rdy = 2'b00;
      acc = -1;
      g   = -1;
      if (!rst) begin
        if (m_owner >= 0)    g = m_owner;
        else if (v == 2'b11) g = m_pref;
        else if (v[0])       g = 0;
        else if (v[1])       g = 1;
        if (g >= 0) begin
          rdy[g] = 1'b1;
          if (v[g]) acc = g;
        end
      end
      a  = (acc == 1) ? bus.req1_addr  : bus.req0_addr;
      we = (acc == 1) ? bus.req1_we    : bus.req0_we;
      wd = (acc == 1) ? bus.req1_wdata : bus.req0_wdata;
      lk = (acc == 1) ? bus.req1_lock  : bus.req0_lock;

      check("ready0", 64'(bus.req0_ready), 64'(rdy[0]));
      check("ready1", 64'(bus.req1_ready), 64'(rdy[1]));
      check("ram_en", 64'(bus.ram_en), 64'(acc >= 0));
      check("ram_we", 64'(bus.ram_we), (acc >= 0) ? 64'(we) : 64'(0));
      if (acc >= 0) begin
        check("ram_addr", 64'(bus.ram_addr), 64'(a));
        check("ram_din", 64'(bus.ram_din), 64'(wd));
      end
      check("rsp0_valid", 64'(bus.rsp0_valid), 64'(!rst && m_rv && m_rwho == 0));
      check("rsp1_valid", 64'(bus.rsp1_valid), 64'(!rst && m_rv && m_rwho == 1));
      if (!rst && m_rv)
        check(m_rwho == 1 ? "rsp1_rdata" : "rsp0_rdata",
              64'(m_rwho == 1 ? bus.rsp1_rdata : bus.rsp0_rdata), 64'(m_rdata));
      check("lock_abort", 64'(bus.lock_abort), 64'(!rst && m_abort));

      if (rst) begin
        m_owner = -1;
        m_pref  = 0;
        m_beats = 0;
        m_rv    = 1'b0;
        m_abort = 1'b0;
      end else begin
        m_rv    = (acc >= 0);
        m_abort = 1'b0;
        if (acc >= 0) begin
          m_rwho  = acc;
          m_rdata = gold[a];
          for (int b = 0; b < int'(NC); b++)
            if (we[b]) gold[a][b*CW +: CW] = wd[b*CW +: CW];
          m_pref  = 1 - acc;
          m_beats = (m_owner < 0) ? 1 : m_beats + 1;
          if (!lk) begin
            m_owner = -1;
            m_beats = 0;
          end else if (m_beats >= int'(LOCK_MAX)) begin
            m_owner = -1;
            m_beats = 0;
            m_abort = 1'b1;
          end else begin
            m_owner = acc;
          end
        end
      end
    end
  end

  task automatic drive(input bit n, input bit v, input int a, input logic [NC-1:0] we,
                       input logic [DW-1:0] wd, input bit lk);
    if (n) begin
      bus.req1_valid = v; bus.req1_addr = AW'(a); bus.req1_we = we;
      bus.req1_wdata = wd; bus.req1_lock = lk;
    end else begin
      bus.req0_valid = v; bus.req0_addr = AW'(a); bus.req0_we = we;
      bus.req0_wdata = wd; bus.req0_lock = lk;
    end
  endtask

  // One cycle of stimulus applied at the falling edge; returns after outputs settle
  task automatic go2(input bit r,
                     input bit v0, input int a0, input logic [NC-1:0] we0, input logic [DW-1:0] wd0, input bit l0,
                     input bit v1, input int a1, input logic [NC-1:0] we1, input logic [DW-1:0] wd1, input bit l1);
    @(negedge clk);
    rst = r;
    drive(1'b0, v0, a0, we0, wd0, l0);
    drive(1'b1, v1, a1, we1, wd1, l1);
    #2;
  endtask

  initial begin : stimulus
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]  = $urandom;
      gold[i] = ram[i];
    end
    ram[5] = 32'hA5A5A5A5; gold[5] = 32'hA5A5A5A5;
    ram[3] = 32'h11223344; gold[3] = 32'h11223344;
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 0, '0, '0, 1'b0);

    // Reset held with both requesters asking
    for (int i = 0; i < 3; i++) go2(1, 1, 5, '0, '0, 1, 1, 6, 4'hF, 32'h1, 1);
    check("rst_ready0", 64'(bus.req0_ready), 64'(0));
    check("rst_ready1", 64'(bus.req1_ready), 64'(0));
    check("rst_ram_en", 64'(bus.ram_en), 64'(0));

    // Single read
    go2(0, 1, 5, '0, '0, 0, 0, 0, '0, '0, 0);
    check("rd_ready0", 64'(bus.req0_ready), 64'(1));
    go2(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    check("rd_rsp0_valid", 64'(bus.rsp0_valid), 64'(1));
    check("rd_rsp0_rdata", 64'(bus.rsp0_rdata), 64'(32'hA5A5A5A5));
    check("rd_rsp1_valid", 64'(bus.rsp1_valid), 64'(0));

    // Contention: grants alternate 0,1,0,1 with back-to-back responses
    go2(0, 0, 0, '0, '0, 0, 1, 7, '0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      go2(0, 1, 20 + i, '0, '0, 0, 1, 40 + i, '0, '0, 0);
      check("rr_ready0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      check("rr_rsp1_valid", 64'(bus.rsp1_valid), 64'(i % 2 == 0));
    end

    // Locked burst from req1 while req0 waits
    go2(0, 1, 30, '0, '0, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      go2(0, 1, 50, '0, '0, 0, 1, 8 + i, '0, '0, i < 3);
      check("burst_ready0", 64'(bus.req0_ready), 64'(0));
      check("burst_ready1", 64'(bus.req1_ready), 64'(1));
    end
    go2(0, 1, 50, '0, '0, 0, 1, 60, '0, '0, 0);
    check("post_burst_ready0", 64'(bus.req0_ready), 64'(1));

    // Byte write returns old data, then the merged word reads back
    go2(0, 1, 3, 4'b0010, 32'h0000AB00, 0, 0, 0, '0, '0, 0);
    go2(0, 1, 3, '0, '0, 0, 0, 0, '0, '0, 0);
    check("bw_old", 64'(bus.rsp0_rdata), 64'(32'h11223344));
    go2(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    check("bw_new", 64'(bus.rsp0_rdata), 64'(32'h1122AB44));

    // Lock abort after LOCK_MAX beats; the next beat goes to req1
    for (int i = 1; i <= 9; i++) begin
      go2(0, 1, 100 + i, '0, '0, 1, i > 1, 200, '0, '0, 0);
      check("abort_ready0", 64'(bus.req0_ready), 64'(i <= 8));
      check("abort_pulse", 64'(bus.lock_abort), 64'(i == 9));
    end
    go2(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

    // Reset while req1 holds a lock with a response outstanding
    go2(0, 0, 0, '0, '0, 0, 1, 300, '0, '0, 1);
    go2(0, 1, 0, '0, '0, 0, 1, 301, '0, '0, 1);
    go2(1, 1, 0, '0, '0, 0, 1, 302, '0, '0, 0);
    check("rl_rsp1_valid", 64'(bus.rsp1_valid), 64'(0));
    go2(0, 1, 0, '0, '0, 0, 1, 303, '0, '0, 0);
    check("rl_ready0", 64'(bus.req0_ready), 64'(1));
    check("rl_ready1", 64'(bus.req1_ready), 64'(0));
    check("rl_rsp1_idle", 64'(bus.rsp1_valid), 64'(0));

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      go2($urandom_range(99) == 0,
          $urandom_range(3) != 0, $urandom_range(15),
          ($urandom_range(1) == 1) ? NC'($urandom) : '0, $urandom, $urandom_range(2) == 0,
          $urandom_range(3) != 0, $urandom_range(15),
          ($urandom_range(1) == 1) ? NC'($urandom) : '0, $urandom, $urandom_range(2) == 0);
    end
    go2(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    go2(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: word address width of the shared RAM port.
REQ-002 SHALL have parameter NUM_COL, default 4: number of byte-write columns.
REQ-003 SHALL have parameter COL_WIDTH, default 8: column width in bits; DATA_WIDTH = NUM_COL*COL_WIDTH.
REQ-004 SHALL have parameter LOCK_MAX, default 8: maximum number of consecutive locked beats.
REQ-005 SHALL have port clk  in  1  sole clock; every register updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have, for each n in {0,1}, port reqn_valid  in  1  access request.
REQ-008 SHALL have, for each n, port reqn_ready  out  1  access accepted this cycle when reqn_valid is also 1.
REQ-009 SHALL have, for each n, port reqn_addr  in  ADDR_WIDTH  word address.
REQ-010 SHALL have, for each n, port reqn_we  in  NUM_COL  byte write enables; all 0 means read.
REQ-011 SHALL have, for each n, port reqn_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have, for each n, port reqn_lock  in  1  keep ownership after this beat.
REQ-013 SHALL have, for each n, port rspn_valid  out  1  response for an accepted beat.
REQ-014 SHALL have, for each n, port rspn_rdata  out  DATA_WIDTH  read data (read-first old data on writes).
REQ-015 SHALL have port ram_en  out  1  RAM port enable.
REQ-016 SHALL have port ram_we  out  NUM_COL  RAM byte write enables.
REQ-017 SHALL have port ram_addr  out  ADDR_WIDTH  RAM address.
REQ-018 SHALL have port ram_din  out  DATA_WIDTH  RAM write data.
REQ-019 SHALL have port ram_dout  in  DATA_WIDTH  RAM registered read data, valid 1 cycle after ram_en.
REQ-020 SHALL have port lock_abort  out  1  one-cycle pulse when a lock is forcibly ended.

Function
REQ-021 SHALL implement FSM states ARB, LOCK0 and LOCK1.
REQ-022 SHALL define accept_n = reqn_valid & reqn_ready, with at most one accept per cycle.
REQ-023 In ARB with exactly one valid requester, that requester SHALL get ready=1 and the other ready=0.
REQ-024 In ARB with both requesters valid, the requester not granted at the last accept SHALL get ready=1 (round-robin).
REQ-025 In ARB with no requester valid, both ready outputs SHALL be 0.
REQ-026 In LOCKn, reqn_ready SHALL be 1 and the other ready SHALL be 0 regardless of valid.
REQ-027 ready outputs and all ram_* outputs SHALL be combinational from the current state and inputs.
REQ-028 On accept_n: ram_en=1, ram_addr=reqn_addr, ram_we=reqn_we, ram_din=reqn_wdata.
REQ-029 With no accept: ram_en=0 and ram_we=0 (ram_addr and ram_din don't-care).
REQ-030 Exactly 1 cycle after accept_n, rspn_valid SHALL be 1 and rspn_rdata SHALL equal ram_dout; otherwise rspn_valid SHALL be 0.
REQ-031 Response routing SHALL use a registered owner tag; back-to-back accepts SHALL yield back-to-back responses with no bubble.
REQ-032 ARB SHALL go to LOCKn on accept_n with reqn_lock=1.
REQ-033 LOCKn SHALL return to ARB on accept_n with reqn_lock=0.
REQ-034 LOCKn with reqn_valid=0 SHALL hold state and counter; the other requester stays blocked.
REQ-035 A beat counter SHALL count accepts in a lock sequence, including the opening beat.
REQ-036 When the counter reaches LOCK_MAX on an accept with lock=1, the FSM SHALL go to ARB, pulse lock_abort for one cycle, and give priority to the other requester; that beat still completes normally.
REQ-037 The counter SHALL clear on every entry to ARB.
REQ-038 Round-robin priority SHALL update on every accept.

Reset
REQ-039 While rst=1: state=ARB, priority to req0, counter=0, rsp0_valid=rsp1_valid=0, lock_abort=0, ram_en=0, ram_we=0, both ready=0.
REQ-040 A response pending when rst asserts SHALL be discarded.
REQ-041 Reset during LOCKn SHALL release the lock.

Verification
REQ-042 Read: mem[5]=0xA5A5A5A5; req0 read addr 5 alone -> ready0=1 at cycle 0, rsp0_valid=1 with rdata=0xA5A5A5A5 at cycle 1, rsp1_valid=0.
REQ-043 Contention: both requesters valid continuously for 4 cycles, no lock -> grants 0,1,0,1 and responses alternate rsp0/rsp1 with no bubble.
REQ-044 Burst lock: req1 issues 4 beats at addr 8..11, lock=1,1,1,0, with req0 valid throughout -> ready0=0 for all 4 beats; req0 granted in the cycle after the last beat.
REQ-045 Byte write: req0 we=4'b0010, wdata=0x0000AB00 to addr 3 holding 0x11223344 -> rsp0 rdata=0x11223344 (old data); a following read returns 0x1122AB44.
REQ-046 Lock abort: LOCK_MAX=8, req0 holds lock=1 for 9 beats with req1 valid -> lock_abort pulses after beat 8; beat 9 goes to req1.
REQ-047 Reset mid-lock: assert rst in LOCK1 with a response pending -> next cycle rsp1_valid=0, state=ARB, req0 wins the first both-valid cycle.
